instr_assembler: RTL and testbench

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

---
 rtl/instr_assembler_pkg.sv | 32 +++
 rtl/instr_byte_packer.sv | 49 ++++
 rtl/instr_assembler.sv | 213 +++++++++++++++++++++
 tb/tb_instr_assembler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_assembler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_assembler_pkg
//  Purpose  : Shared types and opcode-field helpers for the instruction
//             assembler (FSM state enum, operand-count field, decode helper).
//  Revision : 1.0 - initial release
// ============================================================================
package instr_assembler_pkg;

   // Assembler control states.
   typedef enum logic [1:0] {
      FETCH_OP   = 2'd0,
      FETCH_OPND = 2'd1,
      PRESENT    = 2'd2
   } state_t;

   // Operand-count field bit positions, counted down from the opcode MSB
   // (0 = opcode[BYTE_W-1], 1 = opcode[BYTE_W-2]).
   localparam int OPND_MSB = 0;
   localparam int OPND_LSB = 1;

   // Widest opcode byte the decode helper accepts.
   localparam int OPCODE_MAX_W = 64;

   // Number of operand bytes following an opcode of width byte_w.
   function automatic logic [1:0] opnd_count(input logic [OPCODE_MAX_W-1:0] opcode,
                                             input int                      byte_w);
      return {opcode[byte_w-1-OPND_MSB], opcode[byte_w-1-OPND_LSB]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_byte_packer
//  Purpose  : Holds the instruction word being assembled; writes one byte
//             into the selected lane (lane 0 = most significant), optionally
//             clearing all other lanes in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_byte_packer #(
   parameter int BYTE_W    = 8,
   parameter int MAX_BYTES = 4,
   parameter int LANE_W    = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          load,
   input  logic [LANE_W-1:0]             lane,
   input  logic [BYTE_W-1:0]             byte_in,
   output logic [BYTE_W*MAX_BYTES-1:0]   word
);

   localparam int OUT_W = BYTE_W * MAX_BYTES;

   logic [OUT_W-1:0] word_q;
   logic [OUT_W-1:0] word_d;

   // Next word: optional clear, then overwrite the addressed lane.
   always_comb begin
      word_d = clear ? '0 : word_q;
      if (load) begin
         for (int k = 0; k < MAX_BYTES; k++) begin
            if (lane == LANE_W'(k)) begin
               word_d[OUT_W-1-k*BYTE_W -: BYTE_W] = byte_in;
            end
         end
      end
   end

   // Word register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) word_q <= '0;
      else       word_q <= word_d;
   end

   assign word = word_q;

endmodule
`default_nettype wire

// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : instr_assembler
//  Purpose  : Fetches a variable-length instruction byte by byte from memory
//             (opcode top two bits = operand count), packs it MSB-first and
//             presents it to the decoder over a valid/ready handshake.
//             flush redirects fetching to flush_addr and drops any partial
//             instruction.
//  Config   : INSTR_ASSEMBLER_PREFETCH_EN - while presenting, prefetch the
//             next opcode into a one-entry buffer and skip FETCH_OP after
//             the transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_assembler
   import instr_assembler_pkg::*;
#(
   parameter int BYTE_W     = 8,
   parameter int MAX_BYTES  = 4,
   parameter int ADDR_W     = 9,
   parameter int START_ADDR = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   output logic                            mem_req,
   output logic [ADDR_W-1:0]               mem_addr,
   input  logic [BYTE_W-1:0]               mem_data,
   input  logic                            mem_valid,
   output logic [BYTE_W*MAX_BYTES-1:0]     out_data,
   output logic [$clog2(MAX_BYTES+1)-1:0]  out_len,
   output logic                            out_err,
   output logic                            out_valid,
   input  logic                            out_ready,
   input  logic                            flush,
   input  logic [ADDR_W-1:0]               flush_addr
);

   localparam int LEN_W  = $clog2(MAX_BYTES + 1);
   localparam int LANE_W = 3;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [LEN_W-1:0]    len_q,   len_d;
   logic                err_q,   err_d;
   logic [1:0]          need_q,  need_d;
   logic [1:0]          cnt_q,   cnt_d;

   logic                accept;
   logic                op_take;
   logic [BYTE_W-1:0]   op_byte;
   logic [1:0]          op_n;
   logic                pk_clear;
   logic                pk_load;
   logic [LANE_W-1:0]   pk_lane;
   logic [BYTE_W-1:0]   pk_byte;

`ifdef INSTR_ASSEMBLER_PREFETCH_EN
   logic                pf_valid_q, pf_valid_d;
   logic [BYTE_W-1:0]   pf_data_q,  pf_data_d;
   // Keep requesting in PRESENT until the prefetch buffer holds an opcode.
   assign mem_req = (state_q != PRESENT) || !pf_valid_q;
`else
   assign mem_req = (state_q != PRESENT);
`endif

   assign accept    = mem_req && mem_valid;
   assign mem_addr  = addr_q;
   assign out_valid = (state_q == PRESENT);
   assign out_len   = len_q;
   assign out_err   = err_q;

   // Next-state, address advance, opcode decode and packer control.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      err_d    = err_q;
      need_d   = need_q;
      cnt_d    = cnt_q;
      op_take  = 1'b0;
      op_byte  = mem_data;
      op_n     = 2'd0;
      pk_clear = 1'b0;
      pk_load  = 1'b0;
      pk_lane  = '0;
      pk_byte  = mem_data;
`ifdef INSTR_ASSEMBLER_PREFETCH_EN
      pf_valid_d = pf_valid_q;
      pf_data_d  = pf_data_q;
`endif

      if (accept) addr_d = addr_q + ADDR_W'(1);

      case (state_q)
         FETCH_OP: begin
            if (accept) op_take = 1'b1;
         end
         FETCH_OPND: begin
            if (accept) begin
               pk_load = 1'b1;
               pk_lane = {1'b0, cnt_q} + 3'd1;
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q + 2'd1 == need_q) state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) begin
`ifdef INSTR_ASSEMBLER_PREFETCH_EN
               // A buffered or same-cycle opcode starts the next instruction.
               if (pf_valid_q) begin
                  op_take    = 1'b1;
                  op_byte    = pf_data_q;
                  pf_valid_d = 1'b0;
               end else if (accept) begin
                  op_take = 1'b1;
               end else begin
                  state_d = FETCH_OP;
               end
`else
               state_d = FETCH_OP;
`endif
            end
`ifdef INSTR_ASSEMBLER_PREFETCH_EN
            else if (accept) begin
               pf_valid_d = 1'b1;
               pf_data_d  = mem_data;
            end
`endif
         end
         default: state_d = FETCH_OP;
      endcase

      // Opcode decode: start a fresh word with the opcode in lane 0.
      if (op_take) begin
         op_n     = opnd_count(OPCODE_MAX_W'(op_byte), BYTE_W);
         pk_clear = 1'b1;
         pk_load  = 1'b1;
         pk_lane  = '0;
         pk_byte  = op_byte;
         cnt_d    = 2'd0;
         need_d   = op_n;
         if (int'(op_n) + 1 > MAX_BYTES) begin
            // Too long for this build: present the opcode alone, flagged.
            len_d   = LEN_W'(1);
            err_d   = 1'b1;
            state_d = PRESENT;
         end else begin
            len_d   = LEN_W'(int'(op_n) + 1);
            err_d   = 1'b0;
            state_d = (op_n == 2'd0) ? PRESENT : FETCH_OPND;
         end
      end

      // Redirect wins over everything, including a byte accepted this cycle.
      if (flush) begin
         state_d  = FETCH_OP;
         addr_d   = flush_addr;
         cnt_d    = 2'd0;
         pk_clear = 1'b0;
         pk_load  = 1'b0;
`ifdef INSTR_ASSEMBLER_PREFETCH_EN
         pf_valid_d = 1'b0;
`endif
      end
   end

   // State and bookkeeping registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH_OP;
         addr_q  <= ADDR_W'(START_ADDR);
         len_q   <= '0;
         err_q   <= 1'b0;
         need_q  <= 2'd0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         err_q   <= err_d;
         need_q  <= need_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef INSTR_ASSEMBLER_PREFETCH_EN
   // One-entry opcode prefetch buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pf_valid_q <= 1'b0;
         pf_data_q  <= '0;
      end else begin
         pf_valid_q <= pf_valid_d;
         pf_data_q  <= pf_data_d;
      end
   end
`endif

   instr_byte_packer #(
      .BYTE_W    (BYTE_W),
      .MAX_BYTES (MAX_BYTES),
      .LANE_W    (LANE_W)
   ) u_packer (
      .clk     (clk),
      .reset   (reset),
      .clear   (pk_clear),
      .load    (pk_load),
      .lane    (pk_lane),
      .byte_in (pk_byte),
      .word    (out_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_instr_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_assembler
//  Purpose  : Self-checking bench for instr_assembler: byte memory model,
//             scoreboard of predicted instructions, per-feature test tasks.
//             A second instance with MAX_BYTES=2 covers over-length opcodes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_assembler;

   localparam int BYTE_W    = 8;
   localparam int MAX_BYTES = 4;
   localparam int ADDR_W    = 9;
   localparam int OUT_W     = 32;
   localparam int LEN_W     = 3;
`ifdef INSTR_ASSEMBLER_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   typedef struct {
      logic [OUT_W-1:0] data;
      logic [LEN_W-1:0] len;
      logic             err;
   } exp_t;

   logic                clk;
   logic                reset;
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic [BYTE_W-1:0]   mem_data;
   logic                mem_valid;
   logic [OUT_W-1:0]    out_data;
   logic [LEN_W-1:0]    out_len;
   logic                out_err;
   logic                out_valid;
   logic                out_ready;
   logic                flush;
   logic [ADDR_W-1:0]   flush_addr;

   logic                mem_req2;
   logic [ADDR_W-1:0]   mem_addr2;
   logic [BYTE_W-1:0]   mem_data2;
   logic                mem_valid2;
   logic [15:0]         out_data2;
   logic [1:0]          out_len2;
   logic                out_err2;
   logic                out_valid2;
   logic                out_ready2;
   logic                flush2;
   logic [ADDR_W-1:0]   flush_addr2;

   logic [7:0]          mem    [0:511];
   bit                  served [0:511];
   bit                  served2;
   bit                  stall_en;
   exp_t                exp_q  [$];
   int                  n_checks;
   int                  n_pass;

   instr_assembler #(.BYTE_W(8), .MAX_BYTES(4), .ADDR_W(9), .START_ADDR(0)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_valid(mem_valid), .out_data(out_data),
      .out_len(out_len), .out_err(out_err), .out_valid(out_valid),
      .out_ready(out_ready), .flush(flush), .flush_addr(flush_addr)
   );

   instr_assembler #(.BYTE_W(8), .MAX_BYTES(2), .ADDR_W(9), .START_ADDR(0)) dut2 (
      .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
      .mem_data(mem_data2), .mem_valid(mem_valid2), .out_data(out_data2),
      .out_len(out_len2), .out_err(out_err2), .out_valid(out_valid2),
      .out_ready(out_ready2), .flush(flush2), .flush_addr(flush_addr2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference decode of the instruction starting at address a.
   function automatic void predict(input logic [8:0] a, output exp_t e, output logic [8:0] nxt);
      logic [7:0] op;
      int         n;
      op     = mem[a];
      n      = int'(op[7:6]);
      e.data = '0;
      e.err  = 1'b0;
      e.data[31:24] = op;
      if (n + 1 > MAX_BYTES) begin
         e.len = 3'd1;
         e.err = 1'b1;
         nxt   = 9'(a + 1);
      end else begin
         e.len = 3'(n + 1);
         for (int k = 1; k <= n; k++) e.data[31-8*k -: 8] = mem[9'(a + k)];
         nxt = 9'(a + n + 1);
      end
   endfunction

   // Make count instructions from address a visible and expected.
   task automatic queue_prog(input logic [8:0] a, input int count);
      exp_t       e;
      logic [8:0] nxt;
      for (int i = 0; i < count; i++) begin
         predict(a, e, nxt);
         for (int k = 0; k < int'(e.len); k++) served[9'(a + k)] = 1'b1;
         exp_q.push_back(e);
         a = nxt;
      end
   endtask

   task automatic clear_served();
      for (int i = 0; i < 512; i++) served[i] = 1'b0;
   endtask

   // One clock: score a handshake about to complete, then answer memory.
   task automatic step();
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_extra: got data=%h len=%0d err=%0b, required no output",
                     out_data, out_len, out_err);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_len !== e.len || out_err !== e.err)
               $display("FAIL scoreboard: got data=%h len=%0d err=%0b, required data=%h len=%0d err=%0b",
                        out_data, out_len, out_err, e.data, e.len, e.err);
            else
               n_pass++;
         end
      end
      @(posedge clk);
      #2;
      if (mem_req && served[mem_addr] && (!stall_en || $urandom_range(0, 2) != 0)) begin
         mem_valid = 1'b1;
         mem_data  = mem[mem_addr];
      end else begin
         mem_valid = 1'b0;
         mem_data  = '0;
      end
      mem_valid2 = mem_req2 && served2 && (mem_addr2 < 9'd2);
      mem_data2  = (mem_addr2 == 9'd0) ? 8'h80 : 8'h05;
      @(negedge clk);
   endtask

   task automatic do_flush(input logic [8:0] a);
      flush      = 1'b1;
      flush_addr = a;
      step();
      flush      = 1'b0;
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      ok = (exp_q.size() == 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 9'h000)
         $display("FAIL reset_fetch: mem_req=%b mem_addr=%h, required 1 000", mem_req, mem_addr);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0)
         $display("FAIL reset_valid: out_valid=%b, required 0", out_valid);
      else n_pass++;
      n_checks++;
      if (out_data !== 32'h0 || out_len !== 3'd0)
         $display("FAIL reset_data: data=%h len=%0d, required 0 0", out_data, out_len);
      else n_pass++;
      n_checks++;
      if (out_err !== 1'b0)
         $display("FAIL reset_err: out_err=%b, required 0", out_err);
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [7:0] prog [10];
      bit         ok;
      int         n;
      prog = '{8'h18, 8'hC5, 8'h11, 8'h22, 8'h33, 8'h40, 8'h99, 8'h80, 8'h01, 8'h02};
      for (int i = 0; i < 10; i++) mem[i] = prog[i];
      out_ready = 1'b1;
      queue_prog(9'h000, 4);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1800_0000 || out_len !== 3'd1 || out_err !== 1'b0)
         $display("FAIL basic_first: valid=%b data=%h len=%0d err=%b, required 1 18000000 1 0",
                  out_valid, out_data, out_len, out_err);
      else n_pass++;
      wait_drain(100, ok);
      n_checks++;
      if (!ok) $display("FAIL basic_drain: %0d outstanding, required 0", exp_q.size());
      else n_pass++;
      n_checks++;
      if (mem_addr !== 9'h00A)
         $display("FAIL basic_addr: mem_addr=%h, required 00a", mem_addr);
      else n_pass++;
   endtask

   task automatic test_max_bytes();
      int n;
      served2 = 1'b1;
      n = 0;
      while (!out_valid2 && n < 20) begin step(); n++; end
      n_checks++;
      if (out_valid2 !== 1'b1 || out_data2 !== 16'h8000 || out_len2 !== 2'd1 ||
          out_err2 !== 1'b1 || mem_addr2 !== 9'h001)
         $display("FAIL maxb_err: valid=%b data=%h len=%0d err=%b addr=%h, required 1 8000 1 1 001",
                  out_valid2, out_data2, out_len2, out_err2, mem_addr2);
      else n_pass++;
      step();
      n = 0;
      while (!out_valid2 && n < 20) begin step(); n++; end
      n_checks++;
      if (out_valid2 !== 1'b1 || out_data2 !== 16'h0500 || out_len2 !== 2'd1 || out_err2 !== 1'b0)
         $display("FAIL maxb_next: valid=%b data=%h len=%0d err=%b, required 1 0500 1 0",
                  out_valid2, out_data2, out_len2, out_err2);
      else n_pass++;
      served2 = 1'b0;
   endtask

   task automatic test_random();
      int n;
      clear_served();
      for (int i = 'h40; i < 'h80; i++) mem[i] = 8'($urandom);
      do_flush(9'h040);
      queue_prog(9'h040, 8);
      stall_en = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      stall_en  = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL random_drain: %0d outstanding, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_hold();
      bit ok;
      bit held;
      int n;
      clear_served();
      mem['h100] = 8'hC5; mem['h101] = 8'h11; mem['h102] = 8'h22;
      mem['h103] = 8'h33; mem['h104] = 8'h05;
      out_ready = 1'b0;
      do_flush(9'h100);
      queue_prog(9'h100, 2);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b1 || out_data !== 32'hC511_2233 || out_len !== 3'd4) held = 1'b0;
         step();
      end
      n_checks++;
      if (!held || out_data !== 32'hC511_2233)
         $display("FAIL hold_stable: data=%h valid=%b, required c5112233 1 throughout", out_data, out_valid);
      else n_pass++;
      n_checks++;
      if (mem_req !== 1'b0) $display("FAIL hold_req: mem_req=%b, required 0", mem_req);
      else n_pass++;
      n_checks++;
      if (mem_addr !== (PF ? 9'h105 : 9'h104))
         $display("FAIL hold_addr: mem_addr=%h, required %h", mem_addr, PF ? 9'h105 : 9'h104);
      else n_pass++;
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_valid !== PF)
         $display("FAIL hold_next: out_valid=%b one cycle after transfer, required %b", out_valid, PF);
      else n_pass++;
      wait_drain(50, ok);
      n_checks++;
      if (!ok) $display("FAIL hold_drain: %0d outstanding, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_flush();
      bit ok;
      clear_served();
      out_ready = 1'b1;
      mem['h180] = 8'h81; mem['h181] = 8'h01; mem['h182] = 8'h02;
      served['h180] = 1'b1; served['h181] = 1'b1;
      do_flush(9'h180);
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 9'h180 || out_valid !== 1'b0)
         $display("FAIL flush_redirect: req=%b addr=%h valid=%b, required 1 180 0", mem_req, mem_addr, out_valid);
      else n_pass++;
      repeat (4) step();
      n_checks++;
      if (mem_addr !== 9'h182 || out_valid !== 1'b0)
         $display("FAIL flush_partial: addr=%h valid=%b, required 182 0", mem_addr, out_valid);
      else n_pass++;
      served['h182] = 1'b1;
      step();
      for (int i = 'h1F0; i < 'h1FF; i++) mem[i] = 8'h00;
      mem['h1FF] = 8'h81; mem['h000] = 8'h5A; mem['h001] = 8'h6B;
      queue_prog(9'h1F0, 16);
      do_flush(9'h1F0);
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 9'h1F0 || out_valid !== 1'b0)
         $display("FAIL flush_accept: req=%b addr=%h valid=%b, required 1 1f0 0", mem_req, mem_addr, out_valid);
      else n_pass++;
      wait_drain(200, ok);
      n_checks++;
      if (!ok) $display("FAIL flush_drain: %0d outstanding, required 0", exp_q.size());
      else n_pass++;
      n_checks++;
      if (mem_addr !== 9'h002)
         $display("FAIL flush_wrap: mem_addr=%h, required 002", mem_addr);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      clear_served();
      mem['h20] = 8'hC1; mem['h21] = 8'h01;
      served['h20] = 1'b1; served['h21] = 1'b1;
      do_flush(9'h020);
      repeat (4) step();
      n_checks++;
      if (mem_addr !== 9'h022 || out_valid !== 1'b0)
         $display("FAIL rstmid_partial: addr=%h valid=%b, required 022 0", mem_addr, out_valid);
      else n_pass++;
      reset = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b0 || mem_addr !== 9'h000)
         $display("FAIL rstmid_async: valid=%b addr=%h, required 0 000", out_valid, mem_addr);
      else n_pass++;
      reset = 1'b0;
      step();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 9'h000 || out_valid !== 1'b0 || out_len !== 3'd0)
         $display("FAIL rstmid_restart: req=%b addr=%h valid=%b len=%0d, required 1 000 0 0",
                  mem_req, mem_addr, out_valid, out_len);
      else n_pass++;
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      reset       = 1'b1;
      out_ready   = 1'b0;
      flush       = 1'b0;
      flush_addr  = '0;
      mem_valid   = 1'b0;
      mem_data    = '0;
      out_ready2  = 1'b1;
      flush2      = 1'b0;
      flush_addr2 = '0;
      mem_valid2  = 1'b0;
      mem_data2   = '0;
      served2     = 1'b0;
      stall_en    = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      clear_served();

      test_reset();
      test_basic();
      test_max_bytes();
      test_random();
      test_hold();
      test_flush();
      test_reset_mid();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
